fsm_trace_buffer: RTL and testbench

Downstream monitor for the `main` state machine. It samples the 4-bit state output `y` every clock and detects each state change. For every completed state visit it records the state code and how many cycles the FSM stayed there, and queues that record in a small FIFO. The FIFO drains over a valid/ready handshake, so a bench or a logging stage can read the state trace without dropping cycles.

---
 rtl/fsm_trace_buffer.sv | 139 +++++++++++++
 tb/tb_fsm_trace_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_trace_buffer.sv
// State-visit trace monitor: records {state, dwell} per completed visit into a valid/ready FIFO.
// Optional FSM_TRACE_SAT_EN makes the dwell counter saturate instead of wrapping.
module fsm_trace_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_state,
  output logic [DW-1:0]            out_dwell,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic {
    ST_UNPRIMED,
    ST_TRACKING
  } trace_state_e;

  trace_state_e r_state;
  trace_state_e w_nextState;

  logic [3:0]    r_cur;
  logic [DW-1:0] r_dwell;
  logic [3:0]    w_curNext;
  logic [DW-1:0] w_dwellNext;
  logic [DW-1:0] w_dwellInc;
  logic          w_change;

  logic [3:0]    r_memState [DEPTH];
  logic [DW-1:0] r_memDwell [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [LW-1:0] r_level;
  logic          r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A saturating counter parks at all-ones until the next state change resets it.
`ifdef FSM_TRACE_SAT_EN
  assign w_dwellInc = (r_dwell == {DW{1'b1}}) ? r_dwell : r_dwell + DW'(1);
`else
  assign w_dwellInc = r_dwell + DW'(1);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_UNPRIMED;
      r_cur   <= '0;
      r_dwell <= '0;
    end else begin
      r_state <= w_nextState;
      r_cur   <= w_curNext;
      r_dwell <= w_dwellNext;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_curNext   = r_cur;
    w_dwellNext = r_dwell;
    w_change    = 1'b0;
    case (r_state)
      ST_UNPRIMED: begin
        w_nextState = ST_TRACKING;
        w_curNext   = y;
        w_dwellNext = DW'(1);
      end
      ST_TRACKING: begin
        if (y != r_cur) begin
          w_change    = 1'b1;
          w_curNext   = y;
          w_dwellNext = DW'(1);
        end else begin
          w_dwellNext = w_dwellInc;
        end
      end
      default: begin
        w_nextState = ST_UNPRIMED;
      end
    endcase
  end

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LEVEL);
  assign w_pop   = !w_empty && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept the push.
  assign w_push  = w_change && (!w_full || w_pop);
  assign w_drop  = w_change && w_full && !w_pop;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_memState[r_wrPtr] <= r_cur;
      r_memDwell[r_wrPtr] <= r_dwell;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_state = w_empty ? 4'd0 : r_memState[r_rdPtr];
  assign out_dwell = w_empty ? '0 : r_memDwell[r_rdPtr];
  assign level     = r_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fsm_trace_buffer.sv
// Self-checking bench for fsm_trace_buffer: vector table plus scoreboard queue of expected entries.
// A second DW=4 instance covers dwell wrap/saturation (FSM_TRACE_SAT_EN).
module tb_fsm_trace_buffer;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic [3:0] y;
  logic       outReady;
  logic       outValid;
  logic [3:0] outState;
  logic [7:0] outDwell;
  logic [2:0] level;
  logic       overflow;

  logic       reset4;
  logic [3:0] y4;
  logic       outReady4;
  logic       outValid4;
  logic [3:0] outState4;
  logic [3:0] outDwell4;
  logic [2:0] level4;
  logic       overflow4;

  int nChecks = 0;
  int nErrors = 0;

  int  expStateQ [$];
  int  expDwellQ [$];
  bit  mPrimed;
  int  mCur;
  int  mDwell;
  bit  mOvf;

  typedef struct {
    bit         doRst;
    logic [3:0] yIn;
    bit         rdy;
    int         expLevel;
    int         expOvf;
  } vec_t;

  vec_t vecs [$];

  fsm_trace_buffer #(.DEPTH(DEPTH), .DW(8)) dut (
    .clock(clock), .reset(reset), .y(y),
    .out_valid(outValid), .out_ready(outReady),
    .out_state(outState), .out_dwell(outDwell),
    .level(level), .overflow(overflow)
  );

  fsm_trace_buffer #(.DEPTH(DEPTH), .DW(4)) dut4 (
    .clock(clock), .reset(reset4), .y(y4),
    .out_valid(outValid4), .out_ready(outReady4),
    .out_state(outState4), .out_dwell(outDwell4),
    .level(level4), .overflow(overflow4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void checkOutput(string name, int act, int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void addVec(bit r, int yv, bit rd, int lv, int ov);
    vec_t v;
    v.doRst = r;
    v.yIn = 4'(yv);
    v.rdy = rd;
    v.expLevel = lv;
    v.expOvf = ov;
    vecs.push_back(v);
  endfunction

  function automatic void modelReset();
    expStateQ.delete();
    expDwellQ.delete();
    mPrimed = 1'b0;
    mCur = 0;
    mDwell = 0;
    mOvf = 1'b0;
  endfunction

  // Returns at a negedge with reset released; the next posedge is the priming sample.
  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    outReady = 1'b0;
    #1;
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_out_state", outState, 0);
    checkOutput("rst_out_dwell", outDwell, 0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] yIn, input bit rdyIn);
    bit mValid;
    bit mPop;
    y = yIn;
    outReady = rdyIn;
    #1;
    mValid = (expStateQ.size() != 0);
    checkOutput("out_valid", outValid, int'(mValid));
    if (mValid) begin
      checkOutput("head_state", outState, expStateQ[0]);
      checkOutput("head_dwell", outDwell, expDwellQ[0]);
    end else begin
      checkOutput("empty_state", outState, 0);
      checkOutput("empty_dwell", outDwell, 0);
    end
    mPop = mValid && rdyIn;
    @(posedge clock);
    if (mPop) begin
      void'(expStateQ.pop_front());
      void'(expDwellQ.pop_front());
    end
    if (!mPrimed) begin
      mPrimed = 1'b1;
      mCur = int'(yIn);
      mDwell = 1;
    end else if (int'(yIn) != mCur) begin
      if (expStateQ.size() < DEPTH) begin
        expStateQ.push_back(mCur);
        expDwellQ.push_back(mDwell);
      end else begin
        mOvf = 1'b1;
      end
      mCur = int'(yIn);
      mDwell = 1;
    end else begin
`ifdef FSM_TRACE_SAT_EN
      mDwell = (mDwell == 255) ? 255 : mDwell + 1;
`else
      mDwell = (mDwell + 1) % 256;
`endif
    end
    #1;
    checkOutput("level_model", level, expStateQ.size());
    checkOutput("overflow_model", overflow, int'(mOvf));
  endtask

  initial begin
    int expDw4;
    reset = 1'b1;
    reset4 = 1'b1;
    y = 4'd0;
    outReady = 1'b0;
    y4 = 4'd0;
    outReady4 = 1'b0;
    modelReset();

    // Dwell counter width 4: visit of 20 cycles.
`ifdef FSM_TRACE_SAT_EN
    expDw4 = 15;
`else
    expDw4 = 4;
`endif
    @(negedge clock);
    reset4 = 1'b0;
    y4 = 4'd9;
    repeat (20) @(posedge clock);
    #1;
    y4 = 4'd2;
    @(posedge clock);
    #1;
    checkOutput("dw4_valid", outValid4, 1);
    checkOutput("dw4_state", outState4, 9);
    checkOutput("dw4_dwell", outDwell4, expDw4);
    checkOutput("dw4_level", level4, 1);

    // Single visit of 5 cycles, then drain it.
    addVec(1, 3, 0, 0, 0);
    addVec(0, 3, 0, 0, 0);
    addVec(0, 3, 0, 0, 0);
    addVec(0, 3, 0, 0, 0);
    addVec(0, 3, 0, 0, 0);
    addVec(0, 7, 0, 1, 0);
    addVec(0, 7, 1, 0, 0);
    addVec(0, 7, 0, 0, 0);
    // Change every cycle: fill, overflow, push+pop while full, drain.
    addVec(1, 0, 0, 0, 0);
    addVec(0, 1, 0, 1, 0);
    addVec(0, 2, 0, 2, 0);
    addVec(0, 3, 0, 3, 0);
    addVec(0, 4, 0, 4, 0);
    addVec(0, 5, 0, 4, 1);
    addVec(0, 6, 1, 4, 1);
    addVec(0, 6, 1, 3, 1);
    addVec(0, 6, 1, 2, 1);
    addVec(0, 6, 1, 1, 1);
    addVec(0, 6, 1, 0, 1);
    addVec(0, 6, 1, 0, 1);
    // Full with ready while changing, no prior overflow.
    addVec(1, 0, 0, 0, 0);
    addVec(0, 1, 0, 1, 0);
    addVec(0, 2, 0, 2, 0);
    addVec(0, 3, 0, 3, 0);
    addVec(0, 4, 0, 4, 0);
    addVec(0, 8, 1, 4, 0);
    // Constant state with ready pulses while empty.
    addVec(1, 1, 1, 0, 0);
    for (int i = 0; i < 9; i++) addVec(0, 1, i[0], 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].doRst) doReset();
      applyStimulus(vecs[i].yIn, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_level", i), level, vecs[i].expLevel);
      checkOutput($sformatf("vec%0d_overflow", i), overflow, vecs[i].expOvf);
    end

    // Asynchronous reset mid-cycle with a full FIFO and overflow set.
    doReset();
    applyStimulus(4'd1, 1'b0);
    applyStimulus(4'd2, 1'b0);
    applyStimulus(4'd3, 1'b0);
    applyStimulus(4'd4, 1'b0);
    applyStimulus(4'd5, 1'b0);
    applyStimulus(4'd6, 1'b0);
    checkOutput("pre_arst_level", level, 4);
    checkOutput("pre_arst_overflow", overflow, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_out_valid", outValid, 0);
    checkOutput("arst_level", level, 0);
    checkOutput("arst_out_state", outState, 0);
    checkOutput("arst_out_dwell", outDwell, 0);
    checkOutput("arst_overflow", overflow, 0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(4'd8, 1'b0);
    checkOutput("prime_no_entry", level, 0);
    applyStimulus(4'd9, 1'b0);
    checkOutput("post_prime_level", level, 1);
    checkOutput("post_prime_state", outState, 8);
    checkOutput("post_prime_dwell", outDwell, 1);
    applyStimulus(4'd9, 1'b1);
    checkOutput("post_pop_level", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
